// File: rtl/audio_framer.sv
// -----------------------------------------------------------------------------
// audio_framer
//
// Collects a continuous stream of 16-bit PCM samples into a circular buffer and
// streams out overlapping frames of FRAME_LEN samples, oldest first. A new
// frame starts after the first FRAME_LEN samples and then every HOP samples.
//
// Ports
//   clk             system clock, all logic on the rising edge
//   rst             asynchronous active-high reset
//   sample_in       signed PCM sample from the capture stage
//   sample_in_valid one-cycle write strobe, never back-pressured
//   out_data        frame sample, oldest first
//   out_valid       out_data / out_first / out_last are valid
//   out_ready       consumer accepts a beat when out_valid && out_ready
//   out_first       first beat of a frame
//   out_last        beat FRAME_LEN of a frame
//   frame_count     frames fully emitted since reset (wraps)
//   overrun         sticky: a frame was dropped or aborted
//   clear_overrun   synchronous clear of overrun (a same-cycle set wins)
//   busy            high while the FSM is in READ (state visibility)
//
// Output handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_data, out_first and
// out_last stay unchanged until that transfer happens (or a frame abort drops
// out_valid). out_valid never depends combinationally on out_ready.
// -----------------------------------------------------------------------------
module audio_framer #(
    parameter int FRAME_LEN = 256,
    parameter int HOP       = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_in,
    input  logic        sample_in_valid,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_first,
    output logic        out_last,
    output logic [15:0] frame_count,
    output logic        overrun,
    input  logic        clear_overrun,
    output logic        busy
);

    localparam int DEPTH = 2 * FRAME_LEN;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(FRAME_LEN + 1);
    localparam int HW    = (HOP > 1) ? $clog2(HOP) : 1;

    localparam logic [AW-1:0] FRAME_OFS  = AW'(FRAME_LEN);
    localparam logic [CW-1:0] FRAME_FULL = CW'(FRAME_LEN);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);
    localparam logic [HW-1:0] HOP_LAST   = HW'(HOP - 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [15:0]   mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_ptr_inc;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] fill;
    logic [HW-1:0] hop_cnt;
    logic [CW-1:0] rd_cnt;     // reads issued for the current frame
    logic [CW-1:0] wr_since;   // writes since the current start address was latched

    logic trigger;
    logic accept;
    logic accept_last;
    logic latch_start;
    logic issue;
    logic abort;
    logic set_overrun;

    // Trigger: the write that completes the first FRAME_LEN samples, or any
    // later write that completes a HOP block. HOP divides FRAME_LEN, so the
    // hop counter is already aligned when fill saturates.
    assign trigger = sample_in_valid &&
                     ((fill == FRAME_LAST) ||
                      ((fill == FRAME_FULL) && (hop_cnt == HOP_LAST)));

    // Buffer depth is a power of two, so modular address arithmetic is free.
    assign wr_ptr_inc = wr_ptr + AW'(1);
    assign start_addr = wr_ptr_inc - FRAME_OFS;

    assign accept      = out_valid && out_ready;
    assign accept_last = accept && out_last;
    assign busy        = (state == READ);

    // -------------------------------------------------------------------------
    // Next-state and control
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        latch_start = 1'b0;
        issue       = 1'b0;
        abort       = 1'b0;
        set_overrun = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt   = READ;
                    latch_start = 1'b1;
                end
            end
            READ: begin
                if (accept_last) begin
                    // A trigger landing exactly on frame completion is taken.
                    if (trigger) begin
                        latch_start = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (sample_in_valid && (wr_since == FRAME_LAST)) begin
                    // The writer has lapped the frame: unread samples are about
                    // to be overwritten. Any concurrent trigger is dropped too.
                    abort       = 1'b1;
                    set_overrun = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    if (trigger) begin
                        set_overrun = 1'b1;
                    end
                    issue = (rd_cnt != FRAME_FULL) && (!out_valid || out_ready);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sample storage (contents survive reset; warm-up restarts via fill)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sample_in_valid) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    // -------------------------------------------------------------------------
    // State, counters and the output register (RAM read lands directly here)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            fill        <= '0;
            hop_cnt     <= '0;
            rd_addr     <= '0;
            rd_cnt      <= '0;
            wr_since    <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_first   <= 1'b0;
            out_last    <= 1'b0;
            frame_count <= '0;
            overrun     <= 1'b0;
        end else begin
            state <= state_nxt;

            if (sample_in_valid) begin
                wr_ptr  <= wr_ptr_inc;
                hop_cnt <= (hop_cnt == HOP_LAST) ? '0 : hop_cnt + HW'(1);
                if (fill != FRAME_FULL) begin
                    fill <= fill + CW'(1);
                end
            end

            if (latch_start) begin
                rd_addr  <= start_addr;
                rd_cnt   <= '0;
                wr_since <= '0;
            end else begin
                if (issue) begin
                    rd_addr <= rd_addr + AW'(1);
                    rd_cnt  <= rd_cnt + CW'(1);
                end
                if (sample_in_valid && (state == READ)) begin
                    wr_since <= wr_since + CW'(1);
                end
            end

            if (abort) begin
                out_valid <= 1'b0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
            end else if (issue) begin
                out_data  <= mem[rd_addr];
                out_valid <= 1'b1;
                out_first <= (rd_cnt == '0);
                out_last  <= (rd_cnt == FRAME_LAST);
            end else if (accept) begin
                out_valid <= 1'b0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
            end

            if (accept_last) begin
                frame_count <= frame_count + 16'd1;
            end

            if (set_overrun) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_framer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_audio_framer
//
// Directed bench for audio_framer at a reduced size (FRAME_LEN=16, HOP=8) so
// that every scenario, including a 600-frame buffer-wrap run, stays short.
// Stimulus tasks push expected beats {first, last, data} into exp_q when a
// sample completes a frame; an independent monitor pops and compares every
// accepted beat and checks that held beats stay stable during stalls.
// -----------------------------------------------------------------------------
module tb_audio_framer;

    localparam int FL = 16;
    localparam int HP = 8;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_in_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_first;
    logic        out_last;
    logic [15:0] frame_count;
    logic        overrun;
    logic        clear_overrun;
    logic        busy;

    always #5 clk = ~clk;

    audio_framer #(
        .FRAME_LEN (FL),
        .HOP       (HP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_first       (out_first),
        .out_last        (out_last),
        .frame_count     (frame_count),
        .overrun         (overrun),
        .clear_overrun   (clear_overrun),
        .busy            (busy)
    );

    // ---------------- scoreboard state ----------------
    logic [17:0] exp_q[$];
    int          checks   = 0;
    int          errors   = 0;
    int          accepted = 0;
    int          n_wr     = 0;
    logic [17:0] held;
    logic [17:0] mon_cur;
    logic [17:0] mon_exp;
    logic        hold_pending = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst || !out_valid) begin
                hold_pending = 1'b0;
            end else begin
                mon_cur = {out_first, out_last, out_data};
                if (hold_pending) begin
                    checks++;
                    if (mon_cur != held) begin
                        errors++;
                        $display("FAIL hold_stable: got %h expected %h", mon_cur, held);
                    end
                end
                if (out_ready) begin
                    accepted++;
                    hold_pending = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected: got %h expected no beat", mon_cur);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_cur != mon_exp) begin
                            errors++;
                            $display("FAIL beat: got first=%0b last=%0b data=%0d expected first=%0b last=%0b data=%0d",
                                     mon_cur[17], mon_cur[16], mon_cur[15:0],
                                     mon_exp[17], mon_exp[16], mon_exp[15:0]);
                        end
                    end
                end else begin
                    held         = mon_cur;
                    hold_pending = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [15:0] v);
        sample_in       = v;
        sample_in_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_in_valid = 1'b0;
    endtask

    // Ramp sample number n carries value base+n; a frame is expected whenever
    // the running count reaches FL, FL+HP, FL+2*HP, ...
    task automatic wr_m(input int base, input bit push);
        n_wr++;
        if (push && n_wr >= FL && ((n_wr - FL) % HP) == 0) begin
            for (int k = FL - 1; k >= 0; k--) begin
                exp_q.push_back({(k == FL - 1), (k == 0), 16'(base + n_wr - k)});
            end
        end
        wr(16'(base + n_wr));
    endtask

    task automatic send(input int base, input int count, input int gap, input bit push);
        for (int i = 0; i < count; i++) begin
            wr_m(base, push);
            idle(gap);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) begin
            idle(1);
        end
        idle(2);
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        n_wr = 0;
        exp_q.delete();
        idle(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int target;
        rst             = 1'b1;
        sample_in       = '0;
        sample_in_valid = 1'b0;
        out_ready       = 1'b1;
        clear_overrun   = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_valid",   out_valid,   0);
        check("rst_out_first",   out_first,   0);
        check("rst_out_last",    out_last,    0);
        check("rst_out_data",    out_data,    0);
        check("rst_frame_count", frame_count, 0);
        check("rst_overrun",     overrun,     0);
        check("rst_busy",        busy,        0);
        rst = 1'b0;
        idle(1);

        // Slow ramp: frame 0 = 1..16, frame 1 = 9..24, two-cycle latency.
        send(0, FL - 1, 99, 1'b1);
        wr_m(0, 1'b1);
        @(negedge clk);
        check("lat_early_valid", out_valid, 0);
        @(negedge clk);
        check("lat_first_valid", out_valid, 1);
        check("lat_first_flag",  out_first, 1);
        check("lat_busy",        busy,      1);
        @(posedge clk);
        #1;
        idle(97);
        send(0, HP, 99, 1'b1);
        drain("ramp_drain");
        check("ramp_frame_count", frame_count, 2);
        check("ramp_overrun",     overrun,     0);

        // Stalled consumer: 1 cycle ready, 3 cycles not ready.
        do_reset();
        out_ready = 1'b0;
        send(100, FL, 0, 1'b1);
        for (int i = 0; i < 80; i++) begin
            out_ready = ((i % 4) == 0);
            idle(1);
        end
        out_ready = 1'b1;
        drain("stall_drain");
        check("stall_frame_count", frame_count, 1);

        // Consumer never ready: hop trigger dropped, then abort on lap.
        do_reset();
        out_ready = 1'b0;
        send(200, FL + HP - 1, 1, 1'b0);
        check("ovr_before_drop", overrun,   0);
        check("stall_out_valid", out_valid, 1);
        clear_overrun = 1'b1;
        wr_m(200, 1'b0);
        clear_overrun = 1'b0;
        check("ovr_set_beats_clear", overrun, 1);
        send(200, HP - 1, 1, 1'b0);
        check("pre_abort_valid", out_valid, 1);
        check("pre_abort_busy",  busy,      1);
        wr_m(200, 1'b0);
        @(negedge clk);
        check("abort_out_valid",   out_valid,   0);
        check("abort_out_last",    out_last,    0);
        check("abort_busy",        busy,        0);
        check("abort_frame_count", frame_count, 0);
        check("abort_overrun",     overrun,     1);
        @(posedge clk);
        #1;
        clear_overrun = 1'b1;
        idle(1);
        clear_overrun = 1'b0;
        check("ovr_cleared", overrun, 0);
        out_ready = 1'b1;
        idle(30);
        check("abort_idle_busy", busy, 0);

        // Trigger exactly on last-beat acceptance: both frames, no overrun.
        do_reset();
        out_ready = 1'b1;
        send(300, FL, 0, 1'b1);
        send(300, HP - 1, 0, 1'b1);
        idle(FL + 1 - HP);
        wr_m(300, 1'b1);
        drain("b2b_drain");
        check("b2b_frame_count", frame_count, 2);
        check("b2b_overrun",     overrun,     0);

        // Reset in the middle of frame 1.
        do_reset();
        target = accepted + FL + 5;
        send(400, FL + HP, 2, 1'b1);
        for (int i = 0; i < 500 && accepted < target; i++) begin
            idle(1);
        end
        check("midrst_reached_beat", (accepted >= target) ? 1 : 0, 1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid",   out_valid,   0);
        check("midrst_out_first",   out_first,   0);
        check("midrst_out_last",    out_last,    0);
        check("midrst_out_data",    out_data,    0);
        check("midrst_frame_count", frame_count, 0);
        check("midrst_busy",        busy,        0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        n_wr = 0;
        idle(1);
        send(500, FL - 1, 0, 1'b1);
        idle(20);
        check("midrst_no_early_frame", frame_count, 0);
        wr_m(500, 1'b1);
        drain("midrst_drain");
        check("midrst_frame_count_after", frame_count, 1);

        // Long run: 600 frames, buffer pointer wraps many times.
        do_reset();
        send(0, FL + 599 * HP, 2, 1'b1);
        drain("wrap_drain");
        check("wrap_frame_count", frame_count, 600);
        check("wrap_overrun",     overrun,     0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
